conv_window_sequencer: RTL

- Controller for the 3x3 convolution window path: walks every valid 3x3 window of a grayscale image held in pixel BRAM.
- Issues the 9 pixel reads per window and drives the window register's shift enable.
- Presents a completed window to the 2-D conv stage with a valid/ready handshake, plus the output-pixel address.
- Sits between the top-level start/done control, the image BRAM read port, the window shift register and the conv datapath.

---
 rtl/conv_window_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/conv_window_sequencer.sv
// Walks every valid 3x3 window of an IMG_W x IMG_H image in pixel BRAM, issues the
// nine reads per window, drives the window shift enable and hands windows to conv.
module conv_window_sequencer #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int ADDR_W  = 6,
    parameter int OADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               bram_en,
    output logic [ADDR_W-1:0]  bram_addr,
    output logic               shift_en,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [OADDR_W-1:0] out_addr
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 3);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 3);
    localparam logic [3:0]       K_LAST   = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_WAIT,
        S_ADVANCE,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [3:0]       k_q, k_d;
    logic             shift_en_q, shift_en_d;

    logic             last_col;
    logic             last_row;
    logic [3:0]       k_row;
    logic [3:0]       k_col;
    logic [ADDR_W-1:0] pix_row;
    logic [ADDR_W-1:0] pix_col;
    logic [ADDR_W-1:0] fetch_addr;
    logic [OADDR_W-1:0] win_addr;

    assign last_col = (col_q == COL_LAST);
    assign last_row = (row_q == ROW_LAST);

    // NOTE: all state updates use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the simulator runs processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            k_q        <= '0;
            shift_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            k_q        <= k_d;
            shift_en_q <= shift_en_d;
        end
    end

    // NOTE: every signal gets a default at the top of the block so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = '0;
                end
            end
            S_FETCH: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            S_DRAIN: state_d = S_WAIT;
            S_WAIT: begin
                if (win_ready) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                k_d = '0;
                if (last_col && last_row) begin
                    state_d = S_DONE;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d = S_FETCH;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The byte read in one cycle arrives the next, so the shift enable trails the read.
    assign shift_en_d = (state_q == S_FETCH);
    assign shift_en   = shift_en_q;

    always_comb begin
        k_row      = k_q / 4'd3;
        k_col      = k_q % 4'd3;
        pix_row    = ADDR_W'(row_q) + ADDR_W'(k_row);
        pix_col    = ADDR_W'(col_q) + ADDR_W'(k_col);
        fetch_addr = pix_row * ADDR_W'(IMG_W) + pix_col;
        win_addr   = OADDR_W'(row_q) * OADDR_W'(IMG_W - 2) + OADDR_W'(col_q);

        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        bram_en   = (state_q == S_FETCH);
        win_valid = (state_q == S_WAIT);
        bram_addr = bram_en ? fetch_addr : '0;
        out_addr  = win_valid ? win_addr : '0;
    end

endmodule
